const_stream_tx: RTL and testbench

Transmit side of the constant-table transfer. On a start pulse it emits one framed burst of WIDTH-bit words over a valid/ready stream: a header (word count), COUNT table words derived from package constants (BASE + k*STEP), and a trailing checksum. It sits between constant-holding packages and any stream consumer that rebuilds the table on its side.

---
 rtl/const_stream_tx.sv | 135 +++++++++++++
 tb/tb_const_stream_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/const_stream_tx.sv
// const_stream_tx
//
// Transmit side of the constant-table transfer. A start request launches one
// framed burst on a valid/ready stream:
//   header   : COUNT (truncated to WIDTH bits)
//   COUNT x  : table word k = (BASE + k*STEP) mod 2^WIDTH
//   checksum : sum of header and all table words, mod 2^WIDTH (o_last=1)
//
// Ports
//   i_clk    clock, all state on rising edge
//   i_rst    asynchronous active-high reset
//   i_start  frame request, sampled only while idle, never queued
//   i_ready  consumer accepts o_data this cycle when o_valid=1
//   o_valid  o_data holds a valid word
//   o_data   current word
//   o_last   current word is the checksum
//   o_busy   a frame is in progress
//   o_done   one-cycle pulse after the checksum transfer
module const_stream_tx #(
    parameter int WIDTH = 10,
    parameter int COUNT = 4,
    parameter int BASE  = 0,
    parameter int STEP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] COUNT_W = WIDTH'(COUNT);
    localparam logic [WIDTH-1:0] LAST_K  = WIDTH'(COUNT - 1);
    localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] acc_q;
    logic             done_q;
    logic             xfer;

    assign xfer   = o_valid & i_ready;
    assign o_done = done_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from state only, so o_valid never follows i_ready
    // combinationally and an asynchronous reset clears them at once.
    always_comb begin
        state_d = state_q;
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                o_valid = 1'b1;
                o_data  = COUNT_W;
                if (i_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                o_valid = 1'b1;
                o_data  = word_q;
                if (i_ready && (k_q == LAST_K)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                o_valid = 1'b1;
                o_data  = acc_q;
                o_last  = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Table words are generated by repeated addition of STEP; all sums wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k_q    <= '0;
            word_q <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == CHECK) && i_ready;
            if ((state_q == IDLE) && i_start) begin
                k_q    <= '0;
                word_q <= BASE_W;
                acc_q  <= '0;
            end else if (xfer && (state_q != CHECK)) begin
                acc_q <= acc_q + o_data;
                if (state_q == DATA) begin
                    word_q <= word_q + STEP_W;
                    if (k_q != LAST_K) begin
                        k_q <= k_q + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_const_stream_tx.sv
// Directed bench for const_stream_tx. Three instances cover the default
// table, a wrapping table (BASE=1020, STEP=3) and a single-word table
// (COUNT=1, BASE=7). Inputs change and outputs are sampled on the falling
// clock edge.
module tb_const_stream_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] ready_v;
    logic [2:0] valid_v;
    logic [2:0] last_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [9:0] data_v [3];

    int         sel;
    logic       m_valid;
    logic       m_last;
    logic       m_busy;
    logic       m_done;
    logic [9:0] m_data;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q [$];
    logic [9:0] got   [$];
    logic       gotl  [$];
    int         valid_cycles;
    int         done_pulses;
    int         done_gap;
    int         restart_hdr;

    always #5 clk = ~clk;

    const_stream_tx #(.WIDTH(10), .COUNT(4), .BASE(0), .STEP(1)) u_def (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_ready(ready_v[0]),
        .o_valid(valid_v[0]), .o_data(data_v[0]), .o_last(last_v[0]),
        .o_busy(busy_v[0]), .o_done(done_v[0])
    );

    const_stream_tx #(.WIDTH(10), .COUNT(4), .BASE(1020), .STEP(3)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_ready(ready_v[1]),
        .o_valid(valid_v[1]), .o_data(data_v[1]), .o_last(last_v[1]),
        .o_busy(busy_v[1]), .o_done(done_v[1])
    );

    const_stream_tx #(.WIDTH(10), .COUNT(1), .BASE(7), .STEP(1)) u_one (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_ready(ready_v[2]),
        .o_valid(valid_v[2]), .o_data(data_v[2]), .o_last(last_v[2]),
        .o_busy(busy_v[2]), .o_done(done_v[2])
    );

    always_comb begin
        m_valid = valid_v[sel];
        m_last  = last_v[sel];
        m_busy  = busy_v[sel];
        m_done  = done_v[sel];
        m_data  = data_v[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Requests one frame on instance s and records every accepted word.
    // rnd draws i_ready at random; restart pulses i_start while in DATA and
    // again on the o_done cycle.
    task automatic run_frame(input int s, input bit rnd, input bit restart, input int budget);
        int         last_cyc;
        bit         stall;
        bit         r;
        logic [9:0] pd;
        logic       pl;
        sel = s;
        got.delete();
        gotl.delete();
        valid_cycles = 0;
        done_pulses  = 0;
        done_gap     = -1;
        restart_hdr  = -1;
        last_cyc     = -1;
        stall        = 1'b0;
        pd           = '0;
        pl           = 1'b0;
        @(negedge clk);
        check($sformatf("idle_before_start_%0d", s), 32'(m_valid), 32'd0);
        start_v[s] = 1'b1;
        ready_v[s] = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start_v[s] = 1'b0;
            if (cyc == 0) begin
                check($sformatf("start_latency_valid_%0d", s), 32'(m_valid), 32'd1);
                check($sformatf("start_latency_hdr_%0d", s), 32'(m_data), 32'(exp_q[0]));
            end
            if (stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(pd));
                check("hold_last", 32'(m_last), 32'(pl));
            end
            if (m_done) begin
                done_pulses++;
                if (last_cyc >= 0 && done_gap < 0) done_gap = cyc - last_cyc;
                if (restart) start_v[s] = 1'b1;
            end
            if (restart && cyc == 2) start_v[s] = 1'b1;
            if (restart && last_cyc >= 0 && cyc == last_cyc + 2)
                restart_hdr = (m_valid && m_data == exp_q[0]) ? 1 : 0;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_v[s] = r;
            if (last_cyc < 0) begin
                if (m_valid) valid_cycles++;
                if (m_valid && r) begin
                    got.push_back(m_data);
                    gotl.push_back(m_last);
                    if (m_last) last_cyc = cyc;
                end
            end
            stall = m_valid && !r && (last_cyc < 0);
            pd    = m_data;
            pl    = m_last;
            if (last_cyc >= 0 && cyc >= last_cyc + 3) break;
        end
        start_v[s] = 1'b0;
        ready_v[s] = 1'b1;
    endtask

    task automatic check_frame(input string tag, input bit full_ready);
        check({tag, "_word_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                check($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(gotl[i]),
                      (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
            end
        end
        check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check({tag, "_done_gap"}, 32'(done_gap), 32'd1);
        if (full_ready) check({tag, "_valid_cycles"}, 32'(valid_cycles), 32'(exp_q.size()));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_v = '0;
        ready_v = '0;
        sel     = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst_valid_%0d", s), 32'(m_valid), 32'd0);
            check($sformatf("rst_data_%0d", s), 32'(m_data), 32'd0);
            check($sformatf("rst_last_%0d", s), 32'(m_last), 32'd0);
            check($sformatf("rst_busy_%0d", s), 32'(m_busy), 32'd0);
            check($sformatf("rst_done_%0d", s), 32'(m_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Default table, consumer always ready.
        exp_q = '{10'd4, 10'd0, 10'd1, 10'd2, 10'd3, 10'd10};
        run_frame(0, 1'b0, 1'b0, 50);
        check_frame("def", 1'b1);

        // Wrapping table: 1020, 1023, 1026->2, 1029->5; checksum 2054 mod 1024 = 6.
        exp_q = '{10'd4, 10'd1020, 10'd1023, 10'd2, 10'd5, 10'd6};
        run_frame(1, 1'b0, 1'b0, 50);
        check_frame("wrap", 1'b1);

        // Default table with random backpressure.
        exp_q = '{10'd4, 10'd0, 10'd1, 10'd2, 10'd3, 10'd10};
        run_frame(0, 1'b1, 1'b0, 400);
        check_frame("rand", 1'b0);

        // Single-word table.
        exp_q = '{10'd1, 10'd7, 10'd8};
        run_frame(2, 1'b0, 1'b0, 50);
        check_frame("one", 1'b1);

        // Start ignored in DATA, accepted on the done cycle.
        exp_q = '{10'd4, 10'd0, 10'd1, 10'd2, 10'd3, 10'd10};
        run_frame(0, 1'b0, 1'b1, 50);
        check_frame("restart", 1'b1);
        check("restart_header", 32'(restart_hdr), 32'd1);
        repeat (12) @(negedge clk);
        check("drained_idle", 32'(m_busy), 32'd0);

        // Reset while table word 2 is stalled.
        sel = 0;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        ready_v[0] = 1'b0;
        check("stall_word2", 32'(m_data), 32'd2);
        @(negedge clk);
        check("stall_word2_held", 32'(m_data), 32'd2);
        check("stall_busy", 32'(m_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(m_valid), 32'd0);
        check("async_rst_busy", 32'(m_busy), 32'd0);
        check("async_rst_data", 32'(m_data), 32'd0);
        check("async_rst_last", 32'(m_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet_valid%0d", i), 32'(m_valid), 32'd0);
            check($sformatf("post_rst_quiet_busy%0d", i), 32'(m_busy), 32'd0);
        end
        run_frame(0, 1'b0, 1'b0, 50);
        check_frame("after_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
